cache_req_queue: RTL and testbench

//  Upstream request stage for the cache: buffers read/write commands in a FIFO and presents them
//  one at a time on the cache request port (addr/read/write/write_data). Holds each request until
//  the cache signals completion, then captures the read data, classifies the access as hit/miss,

---
 rtl/cache_req_queue.sv | 164 ++++++++++++++++
 tb/tb_cache_req_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_queue.sv
`default_nettype none
// ============================================================================
// Module  : cache_req_queue
// Purpose : FIFO-buffered request stage that issues commands to the cache one at a
//           time, classifies hit/miss, measures latency and keeps hit/miss counters.
// Rev     : 1.0
// ============================================================================
module cache_req_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 14,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic                  cache_read,
    output logic                  cache_write,
    output logic [DATA_WIDTH-1:0] cache_write_data,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_data,
    input  logic                  cache_strob,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_hit,
    output logic                  rsp_timeout,
    output logic [7:0]            rsp_latency,
    output logic [15:0]           hit_cnt,
    output logic [15:0]           miss_cnt
);
    localparam int             PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL      = (PTR_W+1)'(DEPTH);
    localparam logic [7:0]     LAT_LIMIT = 8'(TIMEOUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic                  fifo_write [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr  [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic [1:0]            state;
    logic [7:0]            lat;

    logic push;
    logic pop;
    logic read_done;
    logic write_done;
    logic done;
    logic timed_out;
    logic finish;
    logic hit_class;

    assign cmd_ready  = (count != FULL);
    assign push       = cmd_valid & cmd_ready;
    // GAP issues directly when work is waiting, so the cache sees exactly one idle cycle.
    assign pop        = ((state == ST_IDLE) || (state == ST_GAP)) && (count != '0);
    assign read_done  = cache_read & cache_strob;
    assign write_done = cache_write & cache_hit & ~cache_strob;
    assign done       = (state == ST_BUSY) & (read_done | write_done);
    assign timed_out  = (state == ST_BUSY) & ~(read_done | write_done) & (lat >= LAT_LIMIT);
    assign finish     = done | timed_out;
    assign hit_class  = read_done ? cache_hit : (lat <= 8'd2);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_ptr] <= cmd_write;
            fifo_addr[wr_ptr]  <= cmd_addr;
            fifo_wdata[wr_ptr] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            lat              <= 8'd0;
            cache_addr       <= '0;
            cache_read       <= 1'b0;
            cache_write      <= 1'b0;
            cache_write_data <= '0;
            rsp_valid        <= 1'b0;
            rsp_write        <= 1'b0;
            rsp_addr         <= '0;
            rsp_data         <= '0;
            rsp_hit          <= 1'b0;
            rsp_timeout      <= 1'b0;
            rsp_latency      <= 8'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_BUSY: begin
                    if (finish) begin
                        state       <= ST_GAP;
                        cache_read  <= 1'b0;
                        cache_write <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_write   <= cache_write;
                        rsp_addr    <= cache_addr;
                        rsp_data    <= read_done ? cache_data : '0;
                        rsp_hit     <= timed_out ? 1'b0 : hit_class;
                        rsp_timeout <= timed_out;
                        rsp_latency <= lat;
                    end else if (lat != 8'hFF) begin
                        lat <= lat + 8'd1;
                    end
                end
                default: begin
                    cache_read  <= 1'b0;
                    cache_write <= 1'b0;
                    state       <= ST_IDLE;
                    if (pop) begin
                        state            <= ST_BUSY;
                        lat              <= 8'd1;
                        cache_addr       <= fifo_addr[rd_ptr];
                        cache_read       <= ~fifo_write[rd_ptr];
                        cache_write      <= fifo_write[rd_ptr];
                        cache_write_data <= fifo_wdata[rd_ptr];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= 16'd0;
            miss_cnt <= 16'd0;
        end else if (done) begin
            if (hit_class) begin
                if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end else begin
                if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_req_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_req_queue
// Purpose : Directed scoreboard bench for cache_req_queue with a small cache model.
// Rev     : 1.0
// ============================================================================
module tb_cache_req_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [13:0] cmd_addr;
    logic [9:0]  cmd_wdata;
    logic [13:0] cache_addr;
    logic        cache_read, cache_write;
    logic [9:0]  cache_write_data;
    logic        cache_hit, cache_strob;
    logic [9:0]  cache_data;
    logic        rsp_valid, rsp_write, rsp_hit, rsp_timeout;
    logic [13:0] rsp_addr;
    logic [9:0]  rsp_data;
    logic [7:0]  rsp_latency;
    logic [15:0] hit_cnt, miss_cnt;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    cache_req_queue #(.DEPTH(4), .DATA_WIDTH(10), .ADDR_WIDTH(14), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cache_addr(cache_addr), .cache_read(cache_read), .cache_write(cache_write),
        .cache_write_data(cache_write_data),
        .cache_hit(cache_hit), .cache_data(cache_data), .cache_strob(cache_strob),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_hit(rsp_hit), .rsp_timeout(rsp_timeout),
        .rsp_latency(rsp_latency), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Cache model: hits answer in the 2nd request cycle, misses in the 6th; 4-word lines.
    logic        stall;
    int unsigned cyc;
    logic [9:0]  wmem    [0:16383];
    bit          written [0:16383];
    bit          loaded  [0:4095];

    function automatic logic [9:0] ram_word(input logic [13:0] a);
        return written[a] ? wmem[a] : (a[9:0] ^ 10'h2A5);
    endfunction

    always_comb begin
        cache_hit   = 1'b0;
        cache_strob = 1'b0;
        cache_data  = 10'd0;
        if (!stall && (cache_read || cache_write)) begin
            if (loaded[cache_addr[13:2]]) begin
                if (cyc == 1) begin
                    cache_hit = 1'b1;
                    if (cache_read) begin
                        cache_strob = 1'b1;
                        cache_data  = ram_word(cache_addr);
                    end
                end
            end else if (cyc == 5) begin
                if (cache_read) begin
                    cache_strob = 1'b1;
                    cache_data  = ram_word(cache_addr);
                end else begin
                    cache_hit = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc <= (cache_read || cache_write) ? cyc + 1 : 0;
        if (cache_write && cache_hit) begin
            wmem[cache_addr]    <= cache_write_data;
            written[cache_addr] <= 1'b1;
        end
        if (cache_hit || cache_strob) loaded[cache_addr[13:2]] <= 1'b1;
    end

    typedef struct {
        logic        w;
        logic [13:0] a;
        logic [9:0]  d;
        logic        h;
        logic        to;
        logic [7:0]  lat;
    } exp_t;
    exp_t sb[$];

    task automatic expect_rsp(input logic w, input logic [13:0] a, input logic [9:0] d,
                              input logic h, input logic to, input logic [7:0] lat);
        exp_t e;
        e.w = w; e.a = a; e.d = d; e.h = h; e.to = to; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor side
    logic t4 = 1'b0, t5 = 1'b0, t6post = 1'b0;
    logic prev_to = 1'b0;
    int   lowrun = 0;
    logic seen_high = 1'b0;
    int   post_rst_active = 0;

    always @(posedge clk) begin
        #1;
        if (t4 && prev_to && sb.size() > 0) begin
            n_checks++;
            if (cache_read !== 1'b1) begin
                n_err++;
                $display("FAIL timeout_reissue: cache_read=%0b expected 1", cache_read);
            end
        end
        prev_to = rsp_valid & rsp_timeout;
        if (rsp_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: addr=%0h with nothing expected", rsp_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_write !== e.w || rsp_addr !== e.a || rsp_data !== e.d ||
                    rsp_hit !== e.h || rsp_timeout !== e.to || rsp_latency !== e.lat ||
                    cache_read !== 1'b0 || cache_write !== 1'b0) begin
                    n_err++;
                    $display("FAIL rsp: got w=%0b a=%0h d=%0h hit=%0b to=%0b lat=%0d rd=%0b wr=%0b expected w=%0b a=%0h d=%0h hit=%0b to=%0b lat=%0d rd=0 wr=0",
                             rsp_write, rsp_addr, rsp_data, rsp_hit, rsp_timeout, rsp_latency,
                             cache_read, cache_write, e.w, e.a, e.d, e.h, e.to, e.lat);
                end
            end
        end
        if (t5) begin
            if (!cache_read) begin
                lowrun++;
            end else begin
                if (seen_high && lowrun > 0) begin
                    n_checks++;
                    if (lowrun != 1) begin
                        n_err++;
                        $display("FAIL b2b_gap: low for %0d cycles expected 1", lowrun);
                    end
                end
                lowrun    = 0;
                seen_high = 1'b1;
            end
        end
        if (t6post && (cache_read || cache_write)) post_rst_active++;
    end

    // Stimulus side
    task automatic push(input logic w, input logic [13:0] a, input logic [9:0] d,
                        output logic acc);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        acc = cmd_ready;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_drain: %0d responses outstanding expected 0", nm, sb.size());
        end
    endtask

    initial begin
        logic acc;
        int   n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_cache_rw", {30'd0, cache_read, cache_write}, 32'd0);
        chk("reset_cache_addr", {18'd0, cache_addr}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_counters", {hit_cnt, miss_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: read miss then same-line read hit
        expect_rsp(1'b0, 14'h0040, 10'h2E5, 1'b0, 1'b0, 8'd6);
        push(1'b0, 14'h0040, 10'h000, acc);
        expect_rsp(1'b0, 14'h0041, 10'h2E4, 1'b1, 1'b0, 8'd2);
        push(1'b0, 14'h0041, 10'h000, acc);
        wait_drain("t1");
        chk("t1_miss_cnt", {16'd0, miss_cnt}, 32'd1);
        chk("t1_hit_cnt", {16'd0, hit_cnt}, 32'd1);

        // 2: write hit, read back
        expect_rsp(1'b1, 14'h0042, 10'h000, 1'b1, 1'b0, 8'd2);
        push(1'b1, 14'h0042, 10'h155, acc);
        expect_rsp(1'b0, 14'h0042, 10'h155, 1'b1, 1'b0, 8'd2);
        push(1'b0, 14'h0042, 10'h000, acc);
        wait_drain("t2");
        chk("t2_hit_cnt", {16'd0, hit_cnt}, 32'd3);

        // 3+4: stalled cache, one request in flight, fill FIFO, then timeouts
        stall = 1'b1;
        t4    = 1'b1;
        expect_rsp(1'b0, 14'h0080, 10'h000, 1'b0, 1'b1, 8'd8);
        push(1'b0, 14'h0080, 10'h000, acc);
        n = 0;
        while (!cache_read && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t3_issued", {31'd0, cache_read}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            expect_rsp(1'b0, 14'h0080 + 14'(i), 10'h000, 1'b0, 1'b1, 8'd8);
            push(1'b0, 14'h0080 + 14'(i), 10'h000, acc);
            if (i == 3) chk("t3_ready_3", {31'd0, cmd_ready}, 32'd1);
        end
        chk("t3_ready_full", {31'd0, cmd_ready}, 32'd0);
        push(1'b0, 14'h00FF, 10'h000, acc);
        chk("t3_fifth_rejected", {31'd0, acc}, 32'd0);
        wait_drain("t4");
        t4 = 1'b0;
        chk("t4_counters", {hit_cnt, miss_cnt}, {16'd3, 16'd1});
        stall = 1'b0;

        // 5: back-to-back hits on one line
        lowrun    = 0;
        seen_high = 1'b0;
        t5        = 1'b1;
        expect_rsp(1'b0, 14'h0040, 10'h2E5, 1'b1, 1'b0, 8'd2);
        expect_rsp(1'b0, 14'h0041, 10'h2E4, 1'b1, 1'b0, 8'd2);
        expect_rsp(1'b0, 14'h0042, 10'h155, 1'b1, 1'b0, 8'd2);
        expect_rsp(1'b0, 14'h0043, 10'h2E6, 1'b1, 1'b0, 8'd2);
        for (int i = 0; i < 4; i++) push(1'b0, 14'h0040 + 14'(i), 10'h000, acc);
        wait_drain("t5");
        t5 = 1'b0;
        chk("t5_counters", {hit_cnt, miss_cnt}, {16'd7, 16'd1});

        // 6: reset while busy on a miss
        push(1'b0, 14'h0100, 10'h000, acc);
        push(1'b0, 14'h0104, 10'h000, acc);
        n = 0;
        while (!cache_read && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_busy", {31'd0, cache_read}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_cache_read_drop", {31'd0, cache_read}, 32'd0);
        chk("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t6_counters_clear", {hit_cnt, miss_cnt}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        t6post = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        t6post = 1'b0;
        chk("t6_no_reissue", post_rst_active, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
